// File: rtl/rob_commit_queue_pkg.sv
// Shared reorder-buffer sizing, tag encoding and entry layout.
// Dispatch and the register file import the same values.
package rob_commit_queue_pkg;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int IDX_W  = $clog2(DEPTH);

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [REG_W-1:0]  reg_t;

  // All-ones tag marks "no producer" and is never handed out.
  localparam tag_t TAG_FREE  = '1;
  localparam tag_t DEPTH_TAG = TAG_W'(DEPTH);

  typedef struct packed {
    reg_t  rd;
    data_t data;
  } rob_payload_t;

  function automatic logic tag_in_range(input tag_t tag);
    return tag < DEPTH_TAG;
  endfunction

endpackage

// File: rtl/rob_commit_queue_if.sv
// Dispatch/CDB/query/commit bundle between the ROB and its neighbours.
interface rob_commit_queue_if;
  import rob_commit_queue_pkg::*;

  logic  flush;
  logic  alloc_req;
  reg_t  alloc_rd;
  logic  alloc_ready;
  tag_t  alloc_tag;
  logic  cdb_valid;
  tag_t  cdb_tag;
  data_t cdb_data;
  tag_t  q1_tag;
  tag_t  q2_tag;
  logic  q1_ready;
  logic  q2_ready;
  data_t q1_data;
  data_t q2_data;
  logic  commit_en;
  reg_t  commit_reg;
  data_t commit_data;
  tag_t  commit_tag;
  tag_t  count;
  logic  empty;

  modport master (
    output flush, alloc_req, alloc_rd, cdb_valid, cdb_tag, cdb_data, q1_tag, q2_tag,
    input  alloc_ready, alloc_tag, q1_ready, q2_ready, q1_data, q2_data,
           commit_en, commit_reg, commit_data, commit_tag, count, empty
  );

  modport slave (
    input  flush, alloc_req, alloc_rd, cdb_valid, cdb_tag, cdb_data, q1_tag, q2_tag,
    output alloc_ready, alloc_tag, q1_ready, q2_ready, q1_data, q2_data,
           commit_en, commit_reg, commit_data, commit_tag, count, empty
  );

endinterface

// File: rtl/rob_entry_array.sv
// ROB entry storage: allocation write, CDB capture, retire clear,
// a head read port and two combinational operand query ports.
module rob_entry_array
  import rob_commit_queue_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  alloc_en,
  input  idx_t  alloc_idx,
  input  reg_t  alloc_rd,
  input  logic  cdb_valid,
  input  tag_t  cdb_tag,
  input  data_t cdb_data,
  input  logic  retire_en,
  input  idx_t  head_idx,
  output logic  head_valid,
  output logic  head_ready,
  output reg_t  head_rd,
  output data_t head_data,
  input  tag_t  q1_tag,
  input  tag_t  q2_tag,
  output logic  q1_ready,
  output logic  q2_ready,
  output data_t q1_data,
  output data_t q2_data
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] ready;
  rob_payload_t     payload [DEPTH];

  idx_t cdb_idx;
  idx_t q1_idx;
  idx_t q2_idx;
  logic capture;

  assign cdb_idx = cdb_tag[IDX_W-1:0];
  assign q1_idx  = q1_tag[IDX_W-1:0];
  assign q2_idx  = q2_tag[IDX_W-1:0];
  assign capture = cdb_valid && tag_in_range(cdb_tag) && valid[cdb_idx] && !flush;

  // Alloc writes the tail slot, which is never valid when alloc is allowed,
  // so it cannot collide with a capture or a retire clear.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
      ready <= '0;
    end else begin
      if (capture)   ready[cdb_idx]   <= 1'b1;
      if (retire_en) valid[head_idx]  <= 1'b0;
      if (alloc_en) begin
        valid[alloc_idx] <= 1'b1;
        ready[alloc_idx] <= 1'b0;
      end
    end
  end

  // NOTE: payload is not reset; valid/ready gate every use of it, so a
  // reset here would only add fan-out to the storage array.
  always_ff @(posedge clk) begin
    if (alloc_en) payload[alloc_idx].rd <= alloc_rd;
    if (capture)  payload[cdb_idx].data <= cdb_data;
  end

  assign head_valid = valid[head_idx];
  assign head_ready = ready[head_idx];
  assign head_rd    = payload[head_idx].rd;
  assign head_data  = payload[head_idx].data;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    q1_ready = 1'b0;
    q1_data  = '0;
    q2_ready = 1'b0;
    q2_data  = '0;
    if (tag_in_range(q1_tag)) begin
      q1_ready = valid[q1_idx] && ready[q1_idx];
      q1_data  = payload[q1_idx].data;
    end
    if (tag_in_range(q2_tag)) begin
      q2_ready = valid[q2_idx] && ready[q2_idx];
      q2_data  = payload[q2_idx].data;
    end
  end

endmodule

// File: rtl/rob_commit_queue.sv
// In-order reorder buffer: head/tail/count control and the registered
// commit port to the register file; storage lives in rob_entry_array.
module rob_commit_queue
  import rob_commit_queue_pkg::*;
(
  input logic              clk,
  input logic              rst,
  rob_commit_queue_if.slave bus
);

  idx_t  head;
  idx_t  tail;
  tag_t  count_q;
  logic  alloc_ok;
  logic  do_alloc;
  logic  do_retire;
  logic  head_valid;
  logic  head_ready;
  reg_t  head_rd;
  data_t head_data;

  // Full blocks allocation even when the head retires on the same edge.
  assign alloc_ok  = (count_q != DEPTH_TAG);
  assign do_alloc  = bus.alloc_req && alloc_ok && !bus.flush;
  assign do_retire = head_valid && head_ready && !bus.flush;

  assign bus.alloc_ready = alloc_ok;
  assign bus.alloc_tag   = TAG_W'(tail);
  assign bus.count       = count_q;
  assign bus.empty       = (count_q == '0);

  rob_entry_array u_entries (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .alloc_en   (do_alloc),
    .alloc_idx  (tail),
    .alloc_rd   (bus.alloc_rd),
    .cdb_valid  (bus.cdb_valid),
    .cdb_tag    (bus.cdb_tag),
    .cdb_data   (bus.cdb_data),
    .retire_en  (do_retire),
    .head_idx   (head),
    .head_valid (head_valid),
    .head_ready (head_ready),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .q1_tag     (bus.q1_tag),
    .q2_tag     (bus.q2_tag),
    .q1_ready   (bus.q1_ready),
    .q2_ready   (bus.q2_ready),
    .q1_data    (bus.q1_data),
    .q2_data    (bus.q2_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (do_alloc)  tail <= tail + IDX_W'(1);
      if (do_retire) head <= head + IDX_W'(1);
      case ({do_alloc, do_retire})
        2'b10:   count_q <= count_q + TAG_W'(1);
        2'b01:   count_q <= count_q - TAG_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Commit fields hold their last value between retirements.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.commit_en   <= 1'b0;
      bus.commit_reg  <= '0;
      bus.commit_data <= '0;
      bus.commit_tag  <= TAG_FREE;
    end else if (do_retire) begin
      bus.commit_en   <= 1'b1;
      bus.commit_reg  <= head_rd;
      bus.commit_data <= head_data;
      bus.commit_tag  <= TAG_W'(head);
    end else begin
      bus.commit_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rob_commit_queue.sv
// Directed bench for rob_commit_queue: commits are checked against a
// scoreboard of expected (rd, data, tag, cycle); state checks are inline.
module tb_rob_commit_queue;
  import rob_commit_queue_pkg::*;

  typedef struct {
    reg_t  rd;
    data_t data;
    tag_t  tag;
    int    cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t sb [$];

  rob_commit_queue_if bus ();

  rob_commit_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every commit strobe must match the oldest expected retirement.
  always @(negedge clk) begin
    if (!rst && bus.commit_en) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_commit: got tag %0d reg %0d data 0x%0h expected none",
                 bus.commit_tag, bus.commit_reg, bus.commit_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("commit_reg",  32'(bus.commit_reg), 32'(e.rd));
        check("commit_data", bus.commit_data, e.data);
        check("commit_tag",  32'(bus.commit_tag), 32'(e.tag));
        check("commit_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 0; bus.alloc_req = 0; bus.alloc_rd = '0;
    bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_data = '0;
    bus.q1_tag = TAG_FREE; bus.q2_tag = TAG_FREE;

    // Reset then idle
    tick(); tick();
    rst = 0;
    tick();
    check("rst_empty",       32'(bus.empty), 1);
    check("rst_count",       32'(bus.count), 0);
    check("rst_alloc_ready", 32'(bus.alloc_ready), 1);
    check("rst_alloc_tag",   32'(bus.alloc_tag), 0);
    check("rst_commit_en",   32'(bus.commit_en), 0);
    check("rst_commit_tag",  32'(bus.commit_tag), 15);
    check("rst_commit_reg",  32'(bus.commit_reg), 0);
    check("rst_commit_data", bus.commit_data, 0);

    // Allocate rd 3,5,7 -> tags 0,1,2
    begin
      int rds [3] = '{3, 5, 7};
      for (int i = 0; i < 3; i++) begin
        bus.alloc_req = 1; bus.alloc_rd = REG_W'(rds[i]);
        #1 check("alloc_tag_seq", 32'(bus.alloc_tag), 32'(i));
        tick();
      end
    end
    bus.alloc_req = 0;
    check("count_3", 32'(bus.count), 3);
    bus.q1_tag = 4'd2; bus.q2_tag = TAG_FREE;
    #1 check("q1_ready_before_cdb", 32'(bus.q1_ready), 0);
    check("q2_ready_free", 32'(bus.q2_ready), 0);

    // Younger result first; nothing may retire until the head is ready
    bus.cdb_valid = 1; bus.cdb_tag = 4'd1; bus.cdb_data = 32'hAA;
    tick();
    bus.cdb_tag = 4'd0; bus.cdb_data = 32'h11;
    sb.push_back('{rd: 5'd3, data: 32'h11, tag: 4'd0, cyc: cyc + 2});
    sb.push_back('{rd: 5'd5, data: 32'hAA, tag: 4'd1, cyc: cyc + 3});
    tick();
    bus.cdb_valid = 0;
    tick(); tick(); tick();
    check("count_after_two_retire", 32'(bus.count), 1);
    check("commit_en_idle", 32'(bus.commit_en), 0);
    check("commit_tag_hold", 32'(bus.commit_tag), 1);
    bus.q1_tag = 4'd1;
    #1 check("q1_retired_not_ready", 32'(bus.q1_ready), 0);

    // Query tag 2 across its CDB
    bus.q1_tag = 4'd2; bus.q2_tag = 4'd15;
    #1 check("q1_ready_pre", 32'(bus.q1_ready), 0);
    bus.cdb_valid = 1; bus.cdb_tag = 4'd2; bus.cdb_data = 32'h55;
    sb.push_back('{rd: 5'd7, data: 32'h55, tag: 4'd2, cyc: cyc + 2});
    tick();
    bus.cdb_valid = 0;
    #1 check("q1_ready_post", 32'(bus.q1_ready), 1);
    check("q1_data_post",  bus.q1_data, 32'h55);
    check("q2_ready_free", 32'(bus.q2_ready), 0);
    check("q2_data_free",  bus.q2_data, 0);
    tick(); tick();
    check("empty_after_tag2", 32'(bus.empty), 1);

    // Allocate + retire in the same cycle with count == 1 (head=tail=3)
    bus.alloc_req = 1; bus.alloc_rd = 5'd9;
    tick();
    bus.alloc_req = 0;
    bus.cdb_valid = 1; bus.cdb_tag = 4'd3; bus.cdb_data = 32'h33;
    tick();
    bus.cdb_valid = 0;
    bus.alloc_req = 1; bus.alloc_rd = 5'd10;
    #1 check("alloc_tag_4", 32'(bus.alloc_tag), 4);
    sb.push_back('{rd: 5'd9, data: 32'h33, tag: 4'd3, cyc: cyc + 1});
    tick();
    check("count_alloc_retire", 32'(bus.count), 1);
    check("alloc_tag_5", 32'(bus.alloc_tag), 5);

    // Build 4 pending (tags 4..7), make the head ready, then flush
    bus.alloc_rd = 5'd11; tick();
    bus.alloc_rd = 5'd12; tick();
    bus.alloc_rd = 5'd13;
    bus.cdb_valid = 1; bus.cdb_tag = 4'd4; bus.cdb_data = 32'h44;
    tick();
    check("count_4", 32'(bus.count), 4);
    bus.flush = 1; bus.alloc_rd = 5'd14;
    bus.cdb_tag = 4'd5; bus.cdb_data = 32'h99;
    tick();
    bus.flush = 0; bus.alloc_req = 0;
    bus.cdb_tag = 4'd5; bus.cdb_data = 32'h77;
    check("flush_empty", 32'(bus.empty), 1);
    check("flush_count", 32'(bus.count), 0);
    check("flush_commit_en", 32'(bus.commit_en), 0);
    check("flush_alloc_tag", 32'(bus.alloc_tag), 0);
    tick();
    bus.cdb_valid = 0;
    bus.q1_tag = 4'd5;
    #1 check("late_cdb_ignored", 32'(bus.q1_ready), 0);
    check("late_cdb_count", 32'(bus.count), 0);
    tick(); tick();

    // Fill all 8 entries from head=tail=0; tail wraps back to 0
    for (int i = 0; i < DEPTH; i++) begin
      bus.alloc_req = 1; bus.alloc_rd = REG_W'(i + 1);
      #1 check("fill_alloc_tag", 32'(bus.alloc_tag), 32'(i));
      tick();
    end
    check("full_count", 32'(bus.count), 8);
    check("full_alloc_ready", 32'(bus.alloc_ready), 0);
    check("full_alloc_tag", 32'(bus.alloc_tag), 0);
    bus.alloc_rd = 5'd20;
    bus.cdb_valid = 1; bus.cdb_tag = 4'd0; bus.cdb_data = 32'hC0;
    sb.push_back('{rd: 5'd1, data: 32'hC0, tag: 4'd0, cyc: cyc + 2});
    tick();
    bus.cdb_valid = 0;
    check("full_blocked_count", 32'(bus.count), 8);
    tick();
    check("full_retire_no_alloc", 32'(bus.count), 7);
    check("wrap_alloc_ready", 32'(bus.alloc_ready), 1);
    check("wrap_alloc_tag", 32'(bus.alloc_tag), 0);
    tick();
    bus.alloc_req = 0;
    check("refill_count", 32'(bus.count), 8);
    check("refill_alloc_tag", 32'(bus.alloc_tag), 1);

    tick(); tick(); tick();
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
